alu_seq_multiplier: RTL
=======================

// Module: alu_seq_multiplier
// PURPOSE
//  Multi-cycle unsigned shift-add multiplier in the execute stage, beside the N-bit ALU built from 1-bit ALU slices.
//  It takes the same operand pair as the ALU. Each cycle it adds the multiplicand into the upper partial product when the current LSB is 1, then shifts right by one.
//  The 2*WIDTH-bit result goes downstream to the HI/LO register pair, and control sees a start/busy/done handshake.
// PARAMETERS
//  WIDTH   32   operand width in bits; the product is 2*WIDTH bits wide
//  CNT_W   6    iteration-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           input   1          rising-edge clock
//  rst_n         input   1          asynchronous reset, active low
//  start         input   1          request a multiply; sampled only in IDLE
//  multiplicand  input   WIDTH      operand A; captured on the accepting edge
//  multiplier    input   WIDTH      operand B; captured on the accepting edge
//  busy          output  1          high while in RUN
//  done          output  1          one-cycle pulse; product is valid in that cycle
//  product       output  2*WIDTH    result register; holds its value until the next done
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, product=0, counter=0, working regs=0.
//  States are IDLE, RUN and DONE. Outputs are decoded from registered state: busy=(state==RUN), done=(state==DONE).
//  IDLE: on an edge with start=1, load mcand<=multiplicand, acc<={WIDTH'b0, multiplier} (2*WIDTH bits), cnt<=0, then go to RUN.
//    With start=0, stay in IDLE.
//  RUN, one iteration per edge:
//    sum = {1'b0, acc[2W-1:W]} + (acc[0] ? {1'b0, mcand} : 0), which is WIDTH+1 bits and keeps the carry.
//    acc <= {sum, acc[W-1:1]}, a right shift by 1 that takes the carry into the MSB.
//    cnt <= cnt+1.
//    On the edge where cnt==WIDTH-1, also write product <= the new acc value and go to DONE.
//  DONE: hold for exactly one cycle, then go to IDLE unconditionally.
//  Latency: start accepted at edge k. Iterations run on edges k+1..k+WIDTH. done is high for the cycle after edge k+WIDTH (the WIDTH+1st cycle after acceptance).
//    Next accept is possible at edge k+WIDTH+2.
//  The product output changes only on the edge that enters DONE. During RUN it keeps the previous result.
//  start while busy or in DONE is ignored. It is not queued, and the operands in flight are not changed.
//  Operand inputs only matter on the accepting edge. Changing them afterwards has no effect.
//  Arithmetic: unsigned only, with no overflow possible (the full 2*WIDTH result is kept).
//    Operands of 0 still take the full WIDTH iterations; there is no early exit.
//  Reset asserted in RUN or DONE: operation is aborted at once, every register goes to its reset value, and no done pulse is issued.
//  After rst_n deasserts, the first accept is possible on the first clean edge with start=1.
// TESTING
//  1. Reset, then start=1 for 1 cycle with A=3, B=5 -> busy for 32 cycles, then done=1 for 1 cycle, product=64'h0F.
//  2. A=B=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001 (checks carry retention into the MSB).
//  3. A=32'h0, B=32'h12345678, and also A=32'h80000000, B=2 -> product=0 and 64'h1_00000000 respectively, each after the full 32-cycle latency.
//  4. Start A=7, B=6; at RUN cycle 10, pulse start with A=9, B=9 -> ignored, product=42.
//     The next start is accepted only after done, and a back-to-back start on the first IDLE cycle gives 81.
//  5. Start A=100, B=200; pull rst_n low at RUN cycle 15 -> busy, done and product are 0 immediately, with no done pulse.
//     After release, A=2, B=3 gives product=6.
//  6. Random unsigned pairs (1000) against a reference model of A*B -> every result matches.
//     done is never high for 2 consecutive cycles, and product is stable between done pulses.

Source files
------------

// File: rtl/alu_seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// alu_seq_multiplier_if
//   Handshake and operand/result bundle between execute-stage control and the
//   sequential shift-add multiplier.
//
//   start         control -> multiplier  request a multiply (honoured in IDLE)
//   multiplicand  control -> multiplier  operand A, WIDTH bits
//   multiplier    control -> multiplier  operand B, WIDTH bits
//   busy          multiplier -> control  iterating
//   done          multiplier -> control  one-cycle pulse, product valid
//   product       multiplier -> HI/LO    2*WIDTH-bit result register
//
//   master : the requesting side (control / testbench)
//   slave  : the multiplier itself
// -----------------------------------------------------------------------------
interface alu_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/alu_seq_multiplier.sv
// -----------------------------------------------------------------------------
// alu_seq_multiplier
//   Unsigned radix-2 shift-add multiplier sitting beside the slice-built ALU.
//   One partial-product iteration per clock; WIDTH iterations per operation,
//   no early exit. The full 2*WIDTH-bit product is kept, so no overflow exists.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    alu_seq_multiplier_if.slave
//            start / multiplicand / multiplier  in
//            busy / done / product              out
//
//   Timing: start accepted at edge k, iterations on edges k+1..k+WIDTH,
//   done high for the cycle after edge k+WIDTH, next accept at k+WIDTH+2.
// -----------------------------------------------------------------------------
module alu_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_seq_multiplier_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 last_iter;

  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  // One shift-add step. The upper half sum is WIDTH+1 bits so the carry out
  // of the add lands in the MSB after the right shift instead of being lost.
  function automatic logic [2*WIDTH-1:0] shift_add_step(
    input logic [2*WIDTH-1:0] acc,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  assign acc_next  = shift_add_step(acc_q, mcand_q);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Control: next-state decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand capture, iteration, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q <= bus.multiplicand;
      acc_q   <= {{WIDTH{1'b0}}, bus.multiplier};
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + CNT_W'(1);
      // product only moves on the edge entering DONE; it holds the previous
      // result for the whole of RUN
      if (last_iter) begin
        product_q <= acc_next;
      end
    end
  end

  // Outputs decoded from registered state
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule
